// File: rtl/adda_pipe.sv
// rtl/adda_pipe.sv - multichannel pipelined DQL = DQLN + (Y >> 2) adder with per-channel Y file
module adda_pipe #(
    parameter int DQLN_W   = 12,
    parameter int Y_W      = 13,
    parameter int CHANNELS = 4,
    parameter int SAT      = 0,
    parameter int Y_RST    = 544,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DQLN_W-1:0] in_dqln,
    input  logic              y_wr_en,
    input  logic [CH_W-1:0]   y_wr_ch,
    input  logic [Y_W-1:0]    y_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DQLN_W-1:0] out_dql,
    output logic              out_ovf
);

    logic [Y_W-1:0]    r_y [CHANNELS];

    logic              r_s1_valid;
    logic [CH_W-1:0]   r_s1_ch;
    logic [DQLN_W-1:0] r_s1_dqln;
    logic [Y_W-1:0]    r_s1_y;

    logic              r_s2_valid;
    logic [CH_W-1:0]   r_s2_ch;
    logic [DQLN_W-1:0] r_s2_dql;
    logic              r_s2_ovf;

    logic              w_s2_load;
    logic              w_in_fire;
    logic [Y_W-1:0]    w_y_rd;
    logic [DQLN_W:0]   w_sum;
    logic              w_ovf;
    logic [DQLN_W-1:0] w_dql;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_in_fire = in_valid && in_ready;

    // Unmapped channel numbers match no entry and therefore read as zero.
    always_comb begin
        w_y_rd = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_ch == CH_W'(c)) begin
                w_y_rd = r_y[c];
            end
        end
    end

    // One extra bit catches positive overflow; Y >> 2 is always non-negative.
    assign w_sum = {r_s1_dqln[DQLN_W-1], r_s1_dqln} + (DQLN_W+1)'(r_s1_y >> 2);
    assign w_ovf = w_sum[DQLN_W] ^ w_sum[DQLN_W-1];
    assign w_dql = ((SAT != 0) && w_ovf) ? {1'b0, {(DQLN_W-1){1'b1}}} : w_sum[DQLN_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_y[c] <= Y_W'(Y_RST);
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (y_wr_en && (y_wr_ch == CH_W'(c))) begin
                    r_y[c] <= y_wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_dqln  <= '0;
            r_s1_y     <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_ch    <= in_ch;
            r_s1_dqln  <= in_dqln;
            r_s1_y     <= w_y_rd;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Payload only changes on a real load, so outputs hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_ch    <= '0;
            r_s2_dql   <= '0;
            r_s2_ovf   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_ch  <= r_s1_ch;
                r_s2_dql <= w_dql;
                r_s2_ovf <= w_ovf;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_ch    = r_s2_ch;
    assign out_dql   = r_s2_dql;
    assign out_ovf   = r_s2_ovf;

endmodule
